pipeline_hazard_controller: RTL and testbench
=============================================

Name: pipeline_hazard_controller

Overview:
- Sequences the 5-stage RV64 subset pipeline (LD, SD, ADDI, ADD/SUB/AND/OR, BEQ) downstream of the instruction decoder.
- Keeps a shadow copy of the EX, MEM and WB stage control state.
- Drives pipeline register enables, flushes and ALU forwarding selects.
- Handshakes the data-memory port and keeps stall/flush performance counters.

Parameters:
- REG_AW, 5, register address width.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID register holds a real instruction.
- id_rs1  in  REG_AW  ID-stage source register 1.
- id_rs2  in  REG_AW  ID-stage source register 2.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_AW  ID-stage destination register.
- id_reg_write  in  1  decoder reg_write for the ID instruction.
- id_mem_read  in  1  decoder mem_read for the ID instruction.
- id_mem_write  in  1  decoder mem_write for the ID instruction.
- id_branch  in  1  decoder branch for the ID instruction.
- ex_branch_taken  in  1  BEQ comparison result in EX (ALU zero).
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  MEM stage holds a valid load/store.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- if_id_flush  out  1  IF/ID becomes a bubble.
- id_ex_en  out  1  ID/EX register enable.
- id_ex_flush  out  1  ID/EX loads a bubble.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- fwd_a  out  2  ALU operand A source: 00 register file, 10 EX/MEM, 01 MEM/WB.
- fwd_b  out  2  ALU operand B source, same encoding as fwd_a.
- stall_cycles  out  CNT_W  saturating count of stalled cycles.
- flush_count  out  CNT_W  saturating count of taken branches.

Behaviour:
- Shadow state per stage:
  - EX stage holds valid, rs1, rs2, rd, reg_write, mem_read, mem_write, branch.
  - MEM stage holds valid, rd, reg_write, mem_read, mem_write.
  - WB stage holds valid, rd, reg_write.
- Reset (rst sampled high at a clk edge):
  - All shadow valids and both counters clear.
  - Reset takes effect on the next edge, including in the middle of a memory wait.
- Outputs after reset, until state changes:
  - pc_en, if_id_en, id_ex_en, ex_mem_en and mem_wb_en are 1.
  - if_id_flush, id_ex_flush and dmem_req are 0.
  - fwd_a and fwd_b are 00.
  - Both counters read 0.
- All control outputs are combinational from shadow state and inputs, with zero-cycle latency.
- Internal conditions:
  - mem_wait = mem.valid & (mem.mem_read | mem.mem_write) & !dmem_ready.
  - dmem_req = mem.valid & (mem.mem_read | mem.mem_write).
  - br_taken = ex.valid & ex.branch & ex_branch_taken.
  - load_use = id_valid & ex.valid & ex.mem_read & ex.rd != 0 & ((id_uses_rs1 & id_rs1 == ex.rd) | (id_uses_rs2 & id_rs2 == ex.rd)).
- Priority 1, mem_wait:
  - All five enables are 0 and both flushes are 0.
  - Shadow state holds.
  - br_taken and load_use are ignored this cycle.
- Priority 2, br_taken:
  - if_id_flush = id_ex_flush = 1, pc_en = 1.
  - Shadow EX loads a bubble.
  - flush_count increments.
  - Suppresses load_use.
- Priority 3, load_use:
  - pc_en = if_id_en = 0, id_ex_flush = 1.
  - ex_mem_en and mem_wb_en stay 1.
  - Shadow EX loads a bubble.
- Otherwise all enables are 1 and both flushes are 0.
- Shadow advance (when not holding):
  - WB <= MEM, MEM <= EX.
  - EX <= ID fields with valid = id_valid, or a bubble (valid = 0) when id_ex_flush is 1.
- Forwarding for the EX instruction (fwd_a uses ex.rs1, fwd_b uses ex.rs2):
  - Select 10 if mem.valid & mem.reg_write & !mem.mem_read & mem.rd != 0 & mem.rd == rs.
  - Else select 01 if wb.valid & wb.reg_write & wb.rd != 0 & wb.rd == rs.
  - Else select 00.
  - MEM always has priority over WB.
  - fwd is 00 when ex.valid is 0.
- stall_cycles increments on every cycle with mem_wait or (load_use & !br_taken).
- Both counters saturate at all-ones.
- Register-file write-before-read handles WB-to-ID bypass; this block does not.

Test Plan:
1. Hold rst high 2 cycles with id_valid = 1 and random ID fields -> all enables 1, flushes 0, fwd 00, dmem_req 0, counters 0; after release, no hazard output for the first ID instruction.
2. LD x5,0(x1) followed by ADD x6,x5,x7:
   - Cycle ADD-in-ID: pc_en = 0, if_id_en = 0, id_ex_flush = 1.
   - Next cycle: ADD in EX with fwd_a = 01, fwd_b = 00.
   - stall_cycles = 1.
3. Back-to-back pairs:
   - ADD x3,x1,x2 then SUB x4,x3,x3 -> fwd_a = fwd_b = 10, no stall.
   - ADDI x0,x0,1 then ADD x4,x0,x0 -> fwd 00.
   - ADD x3 then NOP then AND x5,x3,x3 -> fwd 01.
4. BEQ in EX with ex_branch_taken = 1 while a load_use hazard is present in ID -> if_id_flush = id_ex_flush = 1, pc_en = 1 for exactly 1 cycle; flush_count = 1, stall_cycles unchanged.
5. SD in MEM with dmem_ready low for 3 cycles, a taken BEQ in EX and a load-use in ID:
   - dmem_req = 1 and all enables 0 for 3 cycles, no flush.
   - stall_cycles += 3.
   - Cycle 4 (dmem_ready = 1): branch flush fires.
6. rst asserted during a dmem_ready-low wait -> next cycle dmem_req = 0, enables 1, counters 0.

Source files
------------

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush/forwarding control for a 5-stage RV64 subset pipeline
//               with a shadow copy of EX/MEM/WB control state and perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_uses_rs1,
    input  logic              id_uses_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_branch,
    input  logic              ex_branch_taken,
    input  logic              dmem_ready,
    output logic              dmem_req,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_en,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);

    localparam logic [REG_AW-1:0] c_REG_ZERO = '0;
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [1:0]        c_FWD_RF   = 2'b00;
    localparam logic [1:0]        c_FWD_MEM  = 2'b10;
    localparam logic [1:0]        c_FWD_WB   = 2'b01;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
    } ex_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
    } mem_state_t;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
    } wb_state_t;

    ex_state_t        r_ex;
    mem_state_t       r_mem;
    wb_state_t        r_wb;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    logic       w_dmem_access;
    logic       w_mem_wait;
    logic       w_br_taken;
    logic       w_load_use;
    logic       w_stall_inc;
    logic       w_flush_inc;
    ex_state_t  w_ex_next;
    mem_state_t w_mem_next;
    wb_state_t  w_wb_next;

    // A load in MEM has no data yet, so only non-load producers forward from EX/MEM.
    function automatic logic [1:0] fwd_select(
        input logic              ex_valid,
        input logic [REG_AW-1:0] rs,
        input mem_state_t        mem_s,
        input wb_state_t         wb_s
    );
        logic [1:0] sel;
        sel = c_FWD_RF;
        if (ex_valid) begin
            if (mem_s.valid && mem_s.reg_write && !mem_s.mem_read &&
                mem_s.rd != c_REG_ZERO && mem_s.rd == rs) begin
                sel = c_FWD_MEM;
            end else if (wb_s.valid && wb_s.reg_write &&
                         wb_s.rd != c_REG_ZERO && wb_s.rd == rs) begin
                sel = c_FWD_WB;
            end
        end
        return sel;
    endfunction

    assign w_dmem_access = r_mem.valid & (r_mem.mem_read | r_mem.mem_write);
    assign w_mem_wait    = w_dmem_access & ~dmem_ready;
    assign w_br_taken    = r_ex.valid & r_ex.branch & ex_branch_taken;
    assign w_load_use    = id_valid & r_ex.valid & r_ex.mem_read & (r_ex.rd != c_REG_ZERO) &
                           ((id_uses_rs1 & (id_rs1 == r_ex.rd)) |
                            (id_uses_rs2 & (id_rs2 == r_ex.rd)));

    assign w_stall_inc = w_mem_wait | (w_load_use & ~w_br_taken);
    assign w_flush_inc = w_br_taken & ~w_mem_wait;

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (w_mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (w_br_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (w_load_use) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        w_ex_next.valid     = id_valid & ~id_ex_flush;
        w_ex_next.rs1       = id_rs1;
        w_ex_next.rs2       = id_rs2;
        w_ex_next.rd        = id_rd;
        w_ex_next.reg_write = id_reg_write;
        w_ex_next.mem_read  = id_mem_read;
        w_ex_next.mem_write = id_mem_write;
        w_ex_next.branch    = id_branch;

        w_mem_next.valid     = r_ex.valid;
        w_mem_next.rd        = r_ex.rd;
        w_mem_next.reg_write = r_ex.reg_write;
        w_mem_next.mem_read  = r_ex.mem_read;
        w_mem_next.mem_write = r_ex.mem_write;

        w_wb_next.valid     = r_mem.valid;
        w_wb_next.rd        = r_mem.rd;
        w_wb_next.reg_write = r_mem.reg_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ex           <= '0;
            r_mem          <= '0;
            r_wb           <= '0;
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (!w_mem_wait) begin
                r_ex  <= w_ex_next;
                r_mem <= w_mem_next;
                r_wb  <= w_wb_next;
            end
            if (w_stall_inc && r_stall_cycles != c_CNT_MAX) begin
                r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
            end
            if (w_flush_inc && r_flush_count != c_CNT_MAX) begin
                r_flush_count <= r_flush_count + c_CNT_ONE;
            end
        end
    end

    assign dmem_req     = w_dmem_access;
    assign fwd_a        = fwd_select(r_ex.valid, r_ex.rs1, r_mem, r_wb);
    assign fwd_b        = fwd_select(r_ex.valid, r_ex.rs2, r_mem, r_wb);
    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Vector-table bench with scoreboard queue for the hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    typedef struct packed {
        logic       idv;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       u1;
        logic       u2;
        logic       rw;
        logic       mr;
        logic       mw;
        logic       br;
    } id_t;

    typedef struct {
        id_t         id;
        logic        bt;
        logic        rdy;
        logic        rst;
        logic [4:0]  en;
        logic [1:0]  fl;
        logic        req;
        logic [1:0]  fa;
        logic [1:0]  fb;
        int unsigned stall;
        int unsigned flush;
    } vec_t;

    localparam logic [4:0] c_EN_ALL  = 5'b11111;
    localparam logic [4:0] c_EN_LU   = 5'b00111;
    localparam logic [4:0] c_EN_NONE = 5'b00000;
    localparam logic [1:0] c_FL_NONE = 2'b00;
    localparam logic [1:0] c_FL_IDEX = 2'b01;
    localparam logic [1:0] c_FL_BOTH = 2'b11;
    localparam logic [1:0] c_F00     = 2'b00;
    localparam logic [1:0] c_F10     = 2'b10;
    localparam logic [1:0] c_F01     = 2'b01;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs1, id_uses_rs2;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_reg_write, id_mem_read, id_mem_write, id_branch;
    logic        ex_branch_taken, dmem_ready;
    logic        dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, mem_wb_en;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] stall_cycles, flush_count;

    logic        d2_req, d2_pc_en, d2_if_id_en, d2_if_id_flush, d2_id_ex_en, d2_id_ex_flush;
    logic        d2_ex_mem_en, d2_mem_wb_en;
    logic [1:0]  d2_fwd_a, d2_fwd_b;
    logic [1:0]  d2_stall, d2_flush;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];
    vec_t sb[$];

    always #5 clk = ~clk;

    pipeline_hazard_controller #(.REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .dmem_req(dmem_req), .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_en(mem_wb_en), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    // Narrow counters so saturation is reachable in a few cycles.
    pipeline_hazard_controller #(.REG_AW(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_branch(id_branch), .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready),
        .dmem_req(d2_req), .pc_en(d2_pc_en), .if_id_en(d2_if_id_en),
        .if_id_flush(d2_if_id_flush), .id_ex_en(d2_id_ex_en), .id_ex_flush(d2_id_ex_flush),
        .ex_mem_en(d2_ex_mem_en), .mem_wb_en(d2_mem_wb_en), .fwd_a(d2_fwd_a),
        .fwd_b(d2_fwd_b), .stall_cycles(d2_stall), .flush_count(d2_flush)
    );

    function automatic id_t nop();
        id_t r = '0;
        return r;
    endfunction

    function automatic id_t ld(input int rd, input int rs1);
        id_t r = '0;
        r.idv = 1'b1; r.rs1 = 5'(rs1); r.u1 = 1'b1; r.rd = 5'(rd); r.rw = 1'b1; r.mr = 1'b1;
        return r;
    endfunction

    function automatic id_t sd(input int rs2, input int rs1);
        id_t r = '0;
        r.idv = 1'b1; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'b1; r.u2 = 1'b1; r.mw = 1'b1;
        return r;
    endfunction

    function automatic id_t addi(input int rd, input int rs1);
        id_t r = '0;
        r.idv = 1'b1; r.rs1 = 5'(rs1); r.u1 = 1'b1; r.rd = 5'(rd); r.rw = 1'b1;
        return r;
    endfunction

    function automatic id_t alu(input int rd, input int rs1, input int rs2);
        id_t r = '0;
        r.idv = 1'b1; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'b1; r.u2 = 1'b1;
        r.rd = 5'(rd); r.rw = 1'b1;
        return r;
    endfunction

    function automatic id_t beq(input int rs1, input int rs2);
        id_t r = '0;
        r.idv = 1'b1; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = 1'b1; r.u2 = 1'b1; r.br = 1'b1;
        return r;
    endfunction

    // Synthetic load+branch control word: lets a taken branch and a load-use coexist.
    function automatic id_t lb(input int rd, input int rs1, input int rs2);
        id_t r;
        r = alu(rd, rs1, rs2);
        r.mr = 1'b1; r.br = 1'b1;
        return r;
    endfunction

    task automatic add(input id_t id, input int bt, input int rdy, input int rs,
                       input logic [4:0] en, input logic [1:0] fl, input int req,
                       input logic [1:0] fa, input logic [1:0] fb,
                       input int unsigned st, input int unsigned fc);
        vec_t v;
        v.id = id; v.bt = (bt != 0); v.rdy = (rdy != 0); v.rst = (rs != 0);
        v.en = en; v.fl = fl; v.req = (req != 0); v.fa = fa; v.fb = fb;
        v.stall = st; v.flush = fc;
        tbl.push_back(v);
    endtask

    task automatic drive(input id_t id, input logic bt, input logic rdy, input logic rs);
        rst = rs; id_valid = id.idv; id_rs1 = id.rs1; id_rs2 = id.rs2; id_rd = id.rd;
        id_uses_rs1 = id.u1; id_uses_rs2 = id.u2; id_reg_write = id.rw;
        id_mem_read = id.mr; id_mem_write = id.mw; id_branch = id.br;
        ex_branch_taken = bt; dmem_ready = rdy;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic cyc(input id_t id, input logic bt, input logic rdy, input logic rs);
        @(posedge clk);
        #1;
        drive(id, bt, rdy, rs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t e;
        // reset hold, then load-use
        add(alu(3,1,2), 0,1,1, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 0, 0);
        add(ld(9,4),    1,1,1, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 0, 0);
        add(ld(5,1),    0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 0, 0);
        add(alu(6,5,7), 0,1,0, c_EN_LU,   c_FL_IDEX, 0, c_F00, c_F00, 0, 0);
        add(alu(6,5,7), 0,1,0, c_EN_ALL,  c_FL_NONE, 1, c_F00, c_F00, 1, 0);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F01, c_F00, 1, 0);
        // back-to-back forwarding pairs, x0 and MEM-over-WB priority
        add(alu(3,1,2), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(alu(4,3,3), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(addi(0,0),  0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F10, c_F10, 1, 0);
        add(alu(4,0,0), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(alu(3,1,2), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(alu(5,3,3), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F01, c_F01, 1, 0);
        add(alu(7,1,1), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(alu(7,2,2), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(alu(8,7,7), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F10, c_F10, 1, 0);
        // taken branch beats load-use
        add(lb(10,1,2), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 0);
        add(alu(11,10,3),1,1,0,c_EN_ALL,  c_FL_BOTH, 0, c_F00, c_F00, 1, 0);
        add(nop(),      1,1,0, c_EN_ALL,  c_FL_NONE, 1, c_F00, c_F00, 1, 1);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 1);
        // memory wait beats branch and load-use
        add(sd(2,1),    0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 1);
        add(lb(12,1,2), 0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 1, 1);
        add(alu(13,12,12),1,0,0,c_EN_NONE,c_FL_NONE, 1, c_F00, c_F00, 1, 1);
        add(alu(13,12,12),1,0,0,c_EN_NONE,c_FL_NONE, 1, c_F00, c_F00, 2, 1);
        add(alu(13,12,12),1,0,0,c_EN_NONE,c_FL_NONE, 1, c_F00, c_F00, 3, 1);
        add(alu(13,12,12),1,1,0,c_EN_ALL, c_FL_BOTH, 1, c_F00, c_F00, 4, 1);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 1, c_F00, c_F00, 4, 2);
        // reset in the middle of a memory wait
        add(sd(2,1),    0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 4, 2);
        add(nop(),      0,1,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 4, 2);
        add(nop(),      0,0,0, c_EN_NONE, c_FL_NONE, 1, c_F00, c_F00, 4, 2);
        add(nop(),      0,0,1, c_EN_NONE, c_FL_NONE, 1, c_F00, c_F00, 5, 2);
        add(nop(),      0,0,0, c_EN_ALL,  c_FL_NONE, 0, c_F00, c_F00, 0, 0);

        drive(nop(), 1'b0, 1'b1, 1'b1);
        @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            drive(tbl[i].id, tbl[i].bt, tbl[i].rdy, tbl[i].rst);
            sb.push_back(tbl[i]);
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("v%0d_en", i),  64'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 64'(e.en));
            chk($sformatf("v%0d_flush", i), 64'({if_id_flush, id_ex_flush}), 64'(e.fl));
            chk($sformatf("v%0d_dmem_req", i), 64'(dmem_req), 64'(e.req));
            chk($sformatf("v%0d_fwd_a", i), 64'(fwd_a), 64'(e.fa));
            chk($sformatf("v%0d_fwd_b", i), 64'(fwd_b), 64'(e.fb));
            chk($sformatf("v%0d_stall_cycles", i), 64'(stall_cycles), 64'(e.stall));
            chk($sformatf("v%0d_flush_count", i), 64'(flush_count), 64'(e.flush));
        end

        // stall counter saturation on the narrow instance
        cyc(nop(), 1'b0, 1'b1, 1'b1);
        cyc(sd(2,1), 1'b0, 1'b1, 1'b0);
        cyc(nop(), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) cyc(nop(), 1'b0, 1'b0, 1'b0);
        cyc(nop(), 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("sat_stall", 64'(d2_stall), 64'(3));
        chk("sat_stall_flush_idle", 64'(d2_flush), 64'(0));

        // flush counter saturation: a taken BEQ every other cycle
        cyc(nop(), 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 10; k++) cyc(beq(1,2), 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk("sat_flush", 64'(d2_flush), 64'(3));
        chk("sat_flush_no_stall", 64'(d2_stall), 64'(0));
        chk("wide_flush_count", 64'(flush_count), 64'(4));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
